product_out_buffer: RTL and testbench

Parametrised successor to the Booth multiplier's final-product register. It captures the raw partial-product register, which is {A, Q, Q-1} and WIDTH_PP bits wide, and drops the Q-1 bit. It then formats the 2*N_BITS-bit product per a selectable mode (low half, high half, saturated, rounded high half). The formatted result is queued in a DEPTH-entry FIFO with a valid/ready output handshake, so the multiplier datapath can start the next operation before the consumer drains the result.

---
 rtl/booth_pkg.sv | 59 +++++
 rtl/product_fifo.sv | 51 +++++
 rtl/product_out_buffer.sv | 64 ++++++
 tb/tb_product_out_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared Booth product formatting types and the {sat,result} formatter.
// Used by the multiplier controller, the output buffer and the bench.
package booth_pkg;

    localparam int MAX_N = 64;

    typedef enum logic [1:0] {
        MODE_LOW  = 2'b00,
        MODE_HIGH = 2'b01,
        MODE_SAT  = 2'b10,
        MODE_RND  = 2'b11
    } prod_mode_t;

    typedef logic [2*MAX_N-1:0] pp_t;
    typedef logic [MAX_N:0]     fmt_t;

    // Works on a zero-extended 2n-bit product; n is an elaboration constant.
    // Bit MAX_N of the result is the clamp flag, bits [n-1:0] the value.
    function automatic fmt_t format_product(input pp_t p, input int unsigned n,
                                            input prod_mode_t mode, input logic is_signed);
        pp_t  mask, l, h, smax, smin, rnd, hsum, res;
        logic sat;
        mask = (pp_t'(1) << n) - pp_t'(1);
        l    = p & mask;
        h    = (p >> n) & mask;
        smax = (pp_t'(1) << (n - 1)) - pp_t'(1);
        smin = pp_t'(1) << (n - 1);
        rnd  = (p >> (n - 1)) & pp_t'(1);
        hsum = (h + rnd) & mask;
        sat  = 1'b0;
        res  = l;
        case (mode)
            MODE_LOW:  res = l;
            MODE_HIGH: res = h;
            MODE_SAT: begin
                if (is_signed) begin
                    // In range only when H is the sign extension of L's top bit.
                    if (h != (((l & smin) != '0) ? mask : '0)) begin
                        sat = 1'b1;
                        res = ((h & smin) != '0) ? smin : smax;
                    end
                end else if (h != '0) begin
                    sat = 1'b1;
                    res = mask;
                end
            end
            MODE_RND: begin
                res = hsum;
                if ((rnd != '0) && (h == (is_signed ? smax : mask))) begin
                    sat = 1'b1;
                    res = h;
                end
            end
            default: res = l;
        endcase
        return {sat, res[MAX_N-1:0]};
    endfunction

endpackage

// File: rtl/product_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; head is presented combinationally.
import booth_pkg::*;

module product_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign valid = (cnt != '0);
    assign full  = (cnt == (AW + 1)'(DEPTH));
    assign count = cnt;
    // Storage is not reset, so an empty FIFO shows zero rather than stale data.
    assign dout  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/product_out_buffer.sv
// Booth final-product register: formats {A,Q} per mode and queues the
// result in a small FIFO with a valid/ready output handshake.
import booth_pkg::*;

module product_out_buffer #(
    parameter int N_BITS   = 32,
    parameter int WIDTH_PP = 2*N_BITS + 1,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH_PP-1:0]      in,
    input  logic                     ld,
    input  logic [1:0]               mode,
    input  logic                     is_signed,
    output logic [N_BITS-1:0]        product,
    output logic                     product_sat,
    output logic                     product_valid,
    input  logic                     product_ready,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    fmt_t              fmt;
    logic              push, pop;
    logic [N_BITS:0]   fifo_din, fifo_dout;
    logic              unused_ok;

    assign fmt      = format_product(pp_t'(in[WIDTH_PP-1:1]), N_BITS,
                                     prod_mode_t'(mode), is_signed);
    assign fifo_din = {fmt[MAX_N], fmt[N_BITS-1:0]};
    assign unused_ok = ^{in[0], fmt[MAX_N-1:N_BITS]};

    // A pop frees the slot on the same edge, so a full FIFO still accepts.
    assign pop  = product_valid && product_ready;
    assign push = ld && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (ld && !push)
            overflow <= 1'b1;
    end

    product_fifo #(
        .WIDTH (N_BITS + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .valid (product_valid),
        .full  (full),
        .count (count)
    );

    assign product     = fifo_dout[N_BITS-1:0];
    assign product_sat = fifo_dout[N_BITS];

endmodule

// File: tb/tb_product_out_buffer.sv
// Self-checking bench for product_out_buffer (N_BITS=8, DEPTH=4) against a
// queue-based arithmetic reference model.
module tb_product_out_buffer;

    localparam int N     = 8;
    localparam int WPP   = 2*N + 1;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [WPP-1:0] in;
    logic           ld;
    logic [1:0]     mode;
    logic           is_signed;
    logic [N-1:0]   product;
    logic           product_sat;
    logic           product_valid;
    logic           product_ready;
    logic           full;
    logic [2:0]     count;
    logic           overflow;

    int n_chk = 0;
    int n_err = 0;
    int q[$];
    bit ovf_m = 1'b0;

    product_out_buffer #(.N_BITS(N), .WIDTH_PP(WPP), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .in            (in),
        .ld            (ld),
        .mode          (mode),
        .is_signed     (is_signed),
        .product       (product),
        .product_sat   (product_sat),
        .product_valid (product_valid),
        .product_ready (product_ready),
        .full          (full),
        .count         (count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {sat,result} from plain integer arithmetic on the 16-bit product.
    function automatic int ref_fmt(int p, int m, bit s);
        int ps, lo, hi, hs, v;
        lo = p % 256;
        hi = p / 256;
        ps = (p >= 32768) ? p - 65536 : p;
        case (m)
            0: return lo;
            1: return hi;
            2: begin
                if (s) begin
                    if (ps >= -128 && ps <= 127) return lo;
                    return (ps > 0) ? (256 | 127) : (256 | 128);
                end
                if (hi == 0) return lo;
                return 256 | 255;
            end
            default: begin
                if (s) begin
                    hs = ps >>> 8;
                    v  = hs + ((lo >= 128) ? 1 : 0);
                    if (v > 127) return 256 | 127;
                    return v & 255;
                end
                v = hi + ((lo >= 128) ? 1 : 0);
                if (v > 255) return 256 | 255;
                return v;
            end
        endcase
    endfunction

    task automatic tick();
        bit pop, push;
        @(posedge clk);
        if (reset) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            pop  = (q.size() > 0) && product_ready;
            push = ld && ((q.size() < DEPTH) || pop);
            if (ld && !push) ovf_m = 1'b1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(ref_fmt(int'(in[WPP-1:1]), int'(mode), is_signed));
        end
        #1;
        chk("count", 32'(count), 32'(q.size()));
        chk("valid", 32'(product_valid), 32'(q.size() > 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (q.size() > 0) begin
            chk("product", 32'(product), 32'(q[0] & 255));
            chk("sat", 32'(product_sat), 32'(q[0] >> 8));
        end
    endtask

    task automatic cyc(input bit l, input int p, input int m, input bit s, input bit r);
        ld            = l;
        in            = {16'(p), 1'($urandom_range(0, 1))};
        mode          = 2'(m);
        is_signed     = s;
        product_ready = r;
        tick();
    endtask

    task automatic head(input string tag, input int exp);
        chk(tag, 32'({product_sat, product}), 32'(exp));
    endtask

    initial begin
        int pp;
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 16'h1234, 0, 0, 0);
        reset = 1'b0;
        chk("rst_product", 32'(product), 32'h0);
        chk("rst_sat", 32'(product_sat), 32'h0);

        // LOW then HIGH, back to back with ready held
        cyc(1, 16'h1234, 0, 0, 1); head("low", 9'h034);
        cyc(1, 16'h1234, 1, 0, 1); head("high", 9'h012);
        cyc(0, 0, 0, 0, 1);

        // SAT cases
        cyc(1, 16'h1234, 2, 0, 1); head("sat_u", 9'h1FF);
        cyc(1, 16'hFFFE, 2, 1, 1); head("sat_s_in", 9'h0FE);
        cyc(1, 16'h8000, 2, 1, 1); head("sat_s_neg", 9'h180);
        cyc(0, 0, 0, 0, 1);

        // RND cases
        cyc(1, 16'h1280, 3, 0, 1); head("rnd_up", 9'h013);
        cyc(1, 16'h127F, 3, 0, 1); head("rnd_dn", 9'h012);
        cyc(1, 16'h7F80, 3, 1, 1); head("rnd_s_ovf", 9'h17F);
        cyc(1, 16'hFF80, 3, 0, 1); head("rnd_u_ovf", 9'h1FF);
        cyc(0, 0, 0, 0, 1);

        // Fill past capacity, then drain
        for (int i = 1; i <= 5; i++) cyc(1, i, 0, 0, 0);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_ovf", 32'(overflow), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            head("drain", i);
            cyc(0, 0, 0, 0, 1);
        end
        chk("drain_valid", 32'(product_valid), 32'h0);

        // Reset mid-stream with ld asserted
        for (int i = 0; i < 3; i++) cyc(1, 16'h0040 + i, 0, 0, 0);
        reset = 1'b1;
        cyc(1, 16'h00AA, 0, 0, 0);
        reset = 1'b0;
        chk("mrst_count", 32'(count), 32'h0);
        chk("mrst_valid", 32'(product_valid), 32'h0);
        chk("mrst_product", 32'(product), 32'h0);
        chk("mrst_ovf", 32'(overflow), 32'h0);
        cyc(1, 16'h0055, 0, 0, 0);
        head("mrst_next", 9'h055);
        cyc(0, 0, 0, 0, 1);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) cyc(1, 16'h0010 + i, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 16'h0020 + i, 0, 0, 1);
        chk("pp_count", 32'(count), 32'h4);
        chk("pp_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) begin
            head("pp_order", 16'h22 + i);
            cyc(0, 0, 0, 0, 1);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 5))
                0: pp = 16'h7F80;
                1: pp = 16'hFF80;
                2: pp = 16'h0080 | ($urandom_range(0, 1) << 15);
                3: pp = 16'hFF7F;
                default: pp = int'($urandom_range(0, 65535));
            endcase
            cyc($urandom_range(0, 9) < 7, pp, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6);
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
